// File: rtl/vga_sram_scanout.sv
// vga_sram_scanout
//   VGA scan-out engine. It generates VGA timing and streams RGB565 pixels from
//   an asynchronous external SRAM straight to the DAC, with no CPU in the path.
//   The frame base is latched once per frame, so software can flip pages.
//   Each source pixel can be replicated 2^SCALE_SHIFT times in x and y.
//   bus_free tells the Nios side when it may use the SRAM (during blanking).
//
// Ports
//   CLOCK_50, reset        system clock; asynchronous active-high reset
//   enable                 1 = fetch and display; 0 = black output, syncs keep running
//   fb_base                base word address of the next frame
//   SRAM_ADDR/DQ           read address / read data {R5,G6,B5}
//   SRAM_CE_N/OE_N         low only while fetching; WE_N=1, UB_N=LB_N=0 tied
//   VGA_CLK                pixel clock, rises mid-period
//   VGA_HS/VS/BLANK_N      syncs and blanking, aligned with the colour outputs
//   VGA_SYNC_N             tied 0
//   VGA_R/G/B              8-bit colour
//   bus_free               1 while the engine is not driving the SRAM
//   frame_start            one-cycle pulse when a new frame begins
module vga_sram_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int PIX_DIV     = 2,
  parameter int SCALE_SHIFT = 0,
  parameter int ADDR_W      = 20,
  parameter int BASE_ADDR   = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic [15:0]       SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              bus_free,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(PIX_DIV);

  localparam logic [HW-1:0]     H_ACT_L   = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     H_SS_L    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     H_SE_L    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT_L   = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     V_SS_L    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     V_SE_L    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0]     DIV_LAST  = DW'(PIX_DIV - 1);
  localparam logic [DW-1:0]     DIV_HALF  = DW'(PIX_DIV / 2);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [ADDR_W-1:0] BASE_L    = ADDR_W'(BASE_ADDR);
  localparam logic [VW-1:0]     REP_MASK  = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic              HS_ACT    = 1'(HS_POL);
  localparam logic              VS_ACT    = 1'(VS_POL);

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

  logic [DW-1:0]     div_cnt, div_next;
  logic              tick;
  logic              vga_clk_q;
  logic [HW-1:0]     h_p0;
  logic [VW-1:0]     v_p0, v_inc;
  logic [ADDR_W-1:0] line_off_p0, base_q, base_sel, addr_next;
  logic              vld_p0, hs_p0, vs_p0, frame_p0, fetch_p0;
  logic              vld_p1, en_p1, hs_p1, vs_p1, ce_n_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              vld_p2, hs_p2, vs_p2;
  logic [7:0]        r_p2, g_p2, b_p2;

  // Pixel tick divider; VGA_CLK is high for the second half of each tick period
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    div_next = tick ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_cnt   <= div_next;
      vga_clk_q <= (div_next >= DIV_HALF);
    end
  end

  // Stage 0: raster counters and decoded timing
  always_comb begin
    v_inc    = v_p0 + 1'b1;
    vld_p0   = (h_p0 < H_ACT_L) && (v_p0 < V_ACT_L);
    hs_p0    = ((h_p0 >= H_SS_L) && (h_p0 < H_SE_L)) ? HS_ACT : ~HS_ACT;
    vs_p0    = ((v_p0 >= V_SS_L) && (v_p0 < V_SE_L)) ? VS_ACT : ~VS_ACT;
    frame_p0 = (h_p0 == '0) && (v_p0 == '0);
    fetch_p0 = vld_p0 & enable;
    // The first pixel of a frame must already use the base being latched on this tick.
    base_sel  = frame_p0 ? fb_base : base_q;
    addr_next = base_sel + line_off_p0 + ADDR_W'(h_p0 >> SCALE_SHIFT);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      h_p0        <= '0;
      v_p0        <= '0;
      line_off_p0 <= '0;
      base_q      <= BASE_L;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && frame_p0;
      if (tick) begin
        if (frame_p0) base_q <= fb_base;
        if (h_p0 == H_LAST) begin
          h_p0 <= '0;
          if (v_p0 == V_LAST) begin
            v_p0        <= '0;
            line_off_p0 <= '0;
          end else begin
            v_p0 <= v_inc;
            // Advance the line offset only when a new source line starts,
            // so each source line repeats 2^SCALE_SHIFT times.
            if ((v_inc & REP_MASK) == '0) line_off_p0 <= line_off_p0 + LINE_STEP;
          end
        end else begin
          h_p0 <= h_p0 + 1'b1;
        end
      end
    end
  end

  // Stage 1: SRAM address and strobes
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      en_p1    <= 1'b0;
      hs_p1    <= ~HS_ACT;
      vs_p1    <= ~VS_ACT;
      ce_n_p1  <= 1'b1;
      addr_p1  <= '0;
      bus_free <= 1'b1;
    end else if (tick) begin
      vld_p1   <= vld_p0;
      en_p1    <= enable;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_p0;
      ce_n_p1  <= ~fetch_p0;
      addr_p1  <= addr_next;
      bus_free <= ~fetch_p0;
    end
  end

  // Stage 2: capture read data and drive the DAC
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      hs_p2  <= ~HS_ACT;
      vs_p2  <= ~VS_ACT;
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
    end else if (tick) begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      if (vld_p1 && en_p1) begin
        r_p2 <= expand5(SRAM_DQ[15:11]);
        g_p2 <= expand6(SRAM_DQ[10:5]);
        b_p2 <= expand5(SRAM_DQ[4:0]);
      end else begin
        r_p2 <= '0;
        g_p2 <= '0;
        b_p2 <= '0;
      end
    end
  end

  assign SRAM_ADDR   = addr_p1;
  assign SRAM_CE_N   = ce_n_p1;
  assign SRAM_OE_N   = ce_n_p1;
  assign SRAM_WE_N   = 1'b1;
  assign SRAM_UB_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_p2;
  assign VGA_VS      = vs_p2;
  assign VGA_BLANK_N = vld_p2;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_p2;
  assign VGA_G       = g_p2;
  assign VGA_B       = b_p2;

endmodule

// File: tb/tb_vga_sram_scanout.sv
// Bench for vga_sram_scanout, using a reduced raster (24x12 ticks, 16x8 active).
// One DUT runs unscaled and one runs with SCALE_SHIFT=1.
// Each SRAM model returns addr[15:0] as the pixel word.
module tb_vga_sram_scanout;

  localparam int HA = 16, HF = 2, HSY = 4, HB = 2, HT = HA + HF + HSY + HB;
  localparam int VA = 8, VF = 1, VSY = 2, VB = 1, VT = VA + VF + VSY + VB;
  localparam int PD = 2;
  localparam int FR = HT * VT;

  logic clk, reset, enable;
  logic [19:0] fb_base;

  logic [19:0] a0, a1;
  logic [15:0] dq0, dq1;
  logic ce0, oe0, we0, ub0, lb0, vclk0, hs0, vs0, bn0, sn0, bf0, fs0;
  logic ce1, oe1, we1, ub1, lb1, vclk1, hs1, vs1, bn1, sn1, bf1, fs1;
  logic [7:0] r0, g0, b0, r1, g1, b1;

  assign dq0 = a0[15:0];
  assign dq1 = a1[15:0];

  vga_sram_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .PIX_DIV(PD), .SCALE_SHIFT(0), .ADDR_W(20), .BASE_ADDR(0)
  ) dut0 (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .fb_base(fb_base),
    .SRAM_ADDR(a0), .SRAM_DQ(dq0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0),
    .SRAM_WE_N(we0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0),
    .VGA_CLK(vclk0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bn0), .VGA_SYNC_N(sn0),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .bus_free(bf0), .frame_start(fs0)
  );

  vga_sram_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .PIX_DIV(PD), .SCALE_SHIFT(1), .ADDR_W(20), .BASE_ADDR(0)
  ) dut1 (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .fb_base(fb_base),
    .SRAM_ADDR(a1), .SRAM_DQ(dq1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1),
    .SRAM_WE_N(we1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1),
    .VGA_CLK(vclk1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bn1), .VGA_SYNC_N(sn1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .bus_free(bf1), .frame_start(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic chk_en = 1'b0;
  logic meas_on = 1'b0;

  logic [19:0] aq0[$];
  logic [19:0] aq1[$];
  logic [23:0] rq[$];

  // Clock cycles since reset release
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Wait until just before the tick that samples stage-0 position p (counted from release).
  task automatic at_pos(input int p);
    while (cyc < PD * (p + 1) - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the expected fetches and pixels of one frame; positions in [offs,offe) have enable low.
  task automatic push_frame(input logic [19:0] base, input int offs, input int offe);
    for (int v = 0; v < VA; v++) begin
      for (int h = 0; h < HA; h++) begin
        int pp;
        logic [19:0] ad0, ad1;
        logic [15:0] w;
        logic [23:0] rgb;
        pp  = v * HT + h;
        ad0 = base + 20'(v * HA + h);
        ad1 = base + 20'((v >> 1) * (HA / 2) + (h >> 1));
        if (base == 20'h0 && v == 1 && h == 5) ad0 = 20'd21;
        w   = ad0[15:0];
        rgb = {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
        if (base == 20'h0F800 && pp == 0) rgb = 24'hFF0000;
        if (pp >= offs && pp < offe) begin
          rq.push_back(24'h0);
        end else begin
          aq0.push_back(ad0);
          aq1.push_back(ad1);
          rq.push_back(rgb);
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hs"},    32'(hs0), 32'd1);
    chk({tag, "_vs"},    32'(vs0), 32'd1);
    chk({tag, "_blank"}, 32'(bn0), 32'd0);
    chk({tag, "_rgb"},   32'({r0, g0, b0}), 32'd0);
    chk({tag, "_ce"},    32'(ce0), 32'd1);
    chk({tag, "_oe"},    32'(oe0), 32'd1);
    chk({tag, "_addr"},  32'(a0), 32'd0);
    chk({tag, "_addr1"}, 32'(a1), 32'd0);
    chk({tag, "_busfree"}, 32'(bf0), 32'd1);
    chk({tag, "_fstart"},  32'(fs0), 32'd0);
    chk({tag, "_vgaclk"},  32'(vclk0), 32'd0);
    chk({tag, "_ties"},    32'({we0, ub0, lb0, sn0}), 32'b1000);
  endtask

  // Scoreboard monitor: one sample per pixel tick, late in the tick period
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      if (vclk0) begin
        if (!ce0) begin
          if (aq0.size() == 0) begin
            checks++; failures++;
            $display("FAIL addr0_extra actual=%h required=none", a0);
          end else chk("addr0", 32'(a0), 32'(aq0.pop_front()));
        end
        if (bn0) begin
          if (rq.size() == 0) begin
            checks++; failures++;
            $display("FAIL rgb_extra actual=%h required=none", {r0, g0, b0});
          end else chk("rgb", 32'({r0, g0, b0}), 32'(rq.pop_front()));
        end
      end
      if (vclk1 && !ce1) begin
        if (aq1.size() == 0) begin
          checks++; failures++;
          $display("FAIL addr1_extra actual=%h required=none", a1);
        end else chk("addr1_scaled", 32'(a1), 32'(aq1.pop_front()));
      end
    end
  end

  // Timing measurement over one frame window
  int m_hs_low, m_vs_low, m_bn_hi, m_hs_falls, m_vs_falls, m_bn_rises, m_bad, m_since;
  logic m_first, m_have, p_hs, p_vs, p_bn;

  always @(negedge clk) begin
    if (meas_on && vclk0) begin
      m_hs_low += int'(!hs0);
      m_vs_low += int'(!vs0);
      m_bn_hi  += int'(bn0);
      m_since++;
      if (!m_first) begin
        if (p_hs && !hs0) begin
          m_hs_falls++;
          if (m_have && m_since != HT) m_bad++;
          m_have  = 1'b1;
          m_since = 0;
        end
        if (p_vs && !vs0) m_vs_falls++;
        if (!p_bn && bn0) m_bn_rises++;
      end
      m_first = 1'b0;
      p_hs = hs0;
      p_vs = vs0;
      p_bn = bn0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; fb_base = 20'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    push_frame(20'h0, 0, 0);
    push_frame(20'h40000, 3 * HT + 5, 5 * HT);
    push_frame(20'h0F800, 0, 0);
    chk_en = 1'b1;

    at_pos(4 * HT + 3);
    fb_base = 20'h40000;

    at_pos(FR);
    m_hs_low = 0; m_vs_low = 0; m_bn_hi = 0; m_hs_falls = 0; m_vs_falls = 0;
    m_bn_rises = 0; m_bad = 0; m_since = 0; m_first = 1'b1; m_have = 1'b0;
    meas_on = 1'b1;

    at_pos(FR + 2 * HT);
    fb_base = 20'h0F800;
    at_pos(FR + 3 * HT + 5);
    enable = 1'b0;
    at_pos(FR + 4 * HT + 8);
    chk("off_ce", 32'(ce0), 32'd1);
    chk("off_oe", 32'(oe0), 32'd1);
    chk("off_busfree", 32'(bf0), 32'd1);
    chk("off_ce1", 32'(ce1), 32'd1);
    chk("off_blank_n", 32'(bn0), 32'd1);
    chk("off_rgb", 32'({r0, g0, b0}), 32'd0);
    at_pos(FR + 5 * HT);
    enable = 1'b1;
    at_pos(FR + 6 * HT + 4);
    chk("on_busfree", 32'(bf0), 32'd0);
    chk("on_ce", 32'(ce0), 32'd0);
    at_pos(FR + 10 * HT);
    chk("vblank_busfree", 32'(bf0), 32'd1);

    at_pos(2 * FR);
    meas_on = 1'b0;
    chk("hs_pulses", 32'(m_hs_falls), 32'(VT));
    chk("hs_period_bad", 32'(m_bad), 32'd0);
    chk("hs_low_ticks", 32'(m_hs_low), 32'(VT * HSY));
    chk("vs_pulses", 32'(m_vs_falls), 32'd1);
    chk("vs_low_ticks", 32'(m_vs_low), 32'(VSY * HT));
    chk("blank_hi_ticks", 32'(m_bn_hi), 32'(HA * VA));
    chk("active_lines", 32'(m_bn_rises), 32'(VA));

    at_pos(3 * FR);
    chk_en = 1'b0;
    chk("addr0_left", 32'(aq0.size()), 32'd0);
    chk("addr1_left", 32'(aq1.size()), 32'd0);
    chk("rgb_left", 32'(rq.size()), 32'd0);

    at_pos(3 * FR + 5 * HT + 10);
    #2;
    reset = 1'b1;
    #1;
    check_reset("midrst");
    fb_base = 20'h0;
    aq0.delete(); aq1.delete(); rq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push_frame(20'h0, 0, 0);
    chk_en = 1'b1;
    while (cyc < 1) begin @(posedge clk); #1; end
    chk("fs_before", 32'(fs0), 32'd0);
    while (cyc < 2) begin @(posedge clk); #1; end
    chk("fs_pulse", 32'(fs0), 32'd1);
    chk("restart_addr", 32'(a0), 32'd0);
    chk("restart_ce", 32'(ce0), 32'd0);
    while (cyc < 3) begin @(posedge clk); #1; end
    chk("fs_after", 32'(fs0), 32'd0);

    at_pos(FR);
    chk_en = 1'b0;
    chk("addr0_left2", 32'(aq0.size()), 32'd0);
    chk("addr1_left2", 32'(aq1.size()), 32'd0);
    chk("rgb_left2", 32'(rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
